data_mem_responder: RTL and testbench

- Memory-side responder for the core's data-memory interface: accepts word-addressed read/write requests with a 4-bit byte-lane mask.
- Serves each request from an internal word array after a configurable number of wait states, then reports completion or an access fault.
- Sits between the load/store controller (the initiator, which drives word address, byte mask, read/write strobes and write data) and the data RAM.
- Provides a busy/done handshake so the pipeline can stall on multi-cycle accesses.

---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 116 +++++++++++
 tb/tb_data_mem_responder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Handshake bundle between the load/store controller (master) and the
// data-memory responder (slave).
interface data_mem_responder_if;
    logic [29:0] address_mem;
    logic [3:0]  mask_byte;
    logic        read;
    logic        write;
    logic [31:0] data_mem_in;
    logic [31:0] data_mem_out;
    logic        busy;
    logic        done;
    logic        fault;

    modport master (
        output address_mem, mask_byte, read, write, data_mem_in,
        input  data_mem_out, busy, done, fault
    );

    modport slave (
        input  address_mem, mask_byte, read, write, data_mem_in,
        output data_mem_out, busy, done, fault
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: serves word reads and byte-masked writes from an
// internal array after WAIT_STATES cycles, reporting done/fault.
module data_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [3:0]    r_count;
    logic [3:0]    w_countNext;
    logic [29:0]   r_addr;
    logic [3:0]    r_mask;
    logic [31:0]   r_wdata;
    logic          r_rd;
    logic          r_wr;
    logic [31:0]   r_dout;
    logic          r_busy;
    logic          r_done;
    logic          r_fault;
    logic [31:0]   r_mem [DEPTH];
    logic          w_req;
    logic          w_fault;
    logic [AW-1:0] w_index;

    assign w_req   = bus.read | bus.write;
    assign w_fault = (r_rd & r_wr) | ({2'b00, r_addr} >= 32'(DEPTH));
    assign w_index = r_addr[AW-1:0];

    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES > 0) begin
                        w_stateNext = WAIT;
                        w_countNext = 4'(WAIT_STATES - 1);
                    end else begin
                        w_stateNext = RESP;
                    end
                end
            end
            WAIT: begin
                if (r_count == 4'd0) w_stateNext = RESP;
                else                 w_countNext = r_count - 4'd1;
            end
            RESP:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
        end
    end

    // Request capture in IDLE; all outputs change together on the RESP->IDLE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_mask  <= '0;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_dout  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            if (r_state == IDLE && w_req) begin
                r_addr  <= bus.address_mem;
                r_mask  <= bus.mask_byte;
                r_wdata <= bus.data_mem_in;
                r_rd    <= bus.read;
                r_wr    <= bus.write;
                r_busy  <= 1'b1;
            end
            if (r_state == RESP) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_fault <= w_fault;
                if (w_fault)   r_dout <= '0;
                else if (r_rd) r_dout <= r_mem[w_index];
            end
        end
    end

    // Array is never reset; a reset before RESP leaves r_state in IDLE so nothing commits.
    always_ff @(posedge clk) begin
        if (r_state == RESP && !w_fault && r_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (r_mask[i]) r_mem[w_index][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign bus.data_mem_out = r_dout;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.fault        = r_fault;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: four responders with WAIT_STATES 1,3,2,0 exercised one at a time.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addrIn;
    logic [3:0]  maskIn;
    logic [31:0] dataIn;
    logic        rdIn;
    logic        wrIn;
    int          sel;
    logic [31:0] dOut [4];
    logic        bsy  [4];
    logic        dn   [4];
    logic        flt  [4];

    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;

    typedef struct {
        int          dut;
        longint      cyc;
        logic [31:0] data;
        logic        flt;
    } exp_t;

    exp_t        q [$];
    logic [31:0] mdl [int];
    logic [31:0] lastOut [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : gDut
        localparam int WS = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 0;
        data_mem_responder_if bus ();
        assign bus.address_mem = addrIn;
        assign bus.mask_byte   = maskIn;
        assign bus.data_mem_in = dataIn;
        assign bus.read        = rdIn && (sel == g);
        assign bus.write       = wrIn && (sel == g);
        assign dOut[g]         = bus.data_mem_out;
        assign bsy[g]          = bus.busy;
        assign dn[g]           = bus.done;
        assign flt[g]          = bus.fault;
        data_mem_responder #(.DEPTH(1024), .WAIT_STATES(WS)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic int wsOf(int d);
        case (d)
            0:       return 1;
            1:       return 3;
            2:       return 2;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    // Reference model: decides fault, updates the word model and predicts data_mem_out.
    function automatic void pushExpect(int d, bit rd, bit wr, logic [29:0] a, logic [3:0] m,
                                       logic [31:0] wd, longint doneCyc);
        exp_t        e;
        bit          bad;
        int          key;
        logic [31:0] w;
        bad = (rd && wr) || (a >= 30'd1024);
        key = d * 2048 + int'(a[10:0]);
        if (bad) begin
            lastOut[d] = 32'h0;
        end else if (rd) begin
            lastOut[d] = mdl.exists(key) ? mdl[key] : 32'hx;
        end else begin
            w = mdl.exists(key) ? mdl[key] : 32'hx;
            for (int i = 0; i < 4; i++) begin
                if (m[i]) w[8*i +: 8] = wd[8*i +: 8];
            end
            if (m != 4'b0000) mdl[key] = w;
        end
        e.dut  = d;
        e.cyc  = doneCyc;
        e.data = lastOut[d];
        e.flt  = bad;
        q.push_back(e);
    endfunction

    task automatic waitDrain();
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0) return;
        end
        checkOutput("timeout", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    task automatic applyStimulus(input int d, input bit rd, input bit wr, input logic [29:0] a,
                                 input logic [3:0] m, input logic [31:0] wd);
        @(negedge clk);
        sel    = d;
        addrIn = a;
        maskIn = m;
        dataIn = wd;
        rdIn   = rd;
        wrIn   = wr;
        pushExpect(d, rd, wr, a, m, wd, cyc + longint'(wsOf(d)) + 2);
        @(negedge clk);
        rdIn = 1'b0;
        wrIn = 1'b0;
        waitDrain();
    endtask

    // Every done must match the head of the scoreboard; fault never appears without done.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (dn[d]) begin
                if (q.size() == 0 || q[0].dut != d) begin
                    checkOutput("strayDone", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    checkOutput("doneCycle", 64'(cyc), 64'(e.cyc));
                    checkOutput("data", 64'(dOut[d]), 64'(e.data));
                    checkOutput("fault", 64'(flt[d]), 64'(e.flt));
                end
            end else if (flt[d]) begin
                checkOutput("strayFault", 64'd1, 64'd0);
            end
        end
    end

    initial begin
        longint c0;
        rst    = 1'b1;
        addrIn = '0;
        maskIn = '0;
        dataIn = '0;
        rdIn   = 1'b0;
        wrIn   = 1'b0;
        sel    = 0;
        for (int d = 0; d < 4; d++) lastOut[d] = 32'h0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            checkOutput("rstBusy", 64'(bsy[d]), 64'd0);
            checkOutput("rstDone", 64'(dn[d]), 64'd0);
            checkOutput("rstData", 64'(dOut[d]), 64'd0);
        end
        rst = 1'b0;

        // WAIT_STATES=1: full word, byte lane, empty mask, faults, top address
        applyStimulus(0, 0, 1, 30'd5, 4'b1111, 32'hDEADBEEF);
        applyStimulus(0, 1, 0, 30'd5, 4'b0000, 32'h0);
        applyStimulus(0, 0, 1, 30'd5, 4'b0100, 32'h00AA0000);
        applyStimulus(0, 1, 0, 30'd5, 4'b1111, 32'h0);
        applyStimulus(0, 0, 1, 30'd5, 4'b0000, 32'hFFFFFFFF);
        applyStimulus(0, 1, 0, 30'd5, 4'b0001, 32'h0);
        applyStimulus(0, 1, 0, 30'd1024, 4'b1111, 32'h0);
        applyStimulus(0, 0, 1, 30'd3, 4'b1111, 32'h33333333);
        applyStimulus(0, 1, 1, 30'd3, 4'b1111, 32'h0);
        applyStimulus(0, 1, 0, 30'd3, 4'b1111, 32'h0);
        applyStimulus(0, 0, 1, 30'd1023, 4'b1111, 32'hCAFEF00D);
        applyStimulus(0, 1, 0, 30'd1023, 4'b1111, 32'h0);
        applyStimulus(0, 0, 1, 30'h3FFFFFFF, 4'b1111, 32'h11111111);

        // WAIT_STATES=0
        applyStimulus(3, 0, 1, 30'd0, 4'b1111, 32'hA5A55A5A);
        applyStimulus(3, 1, 0, 30'd0, 4'b1111, 32'h0);
        applyStimulus(3, 0, 1, 30'd0, 4'b1001, 32'h11223344);
        applyStimulus(3, 1, 0, 30'd0, 4'b1111, 32'h0);

        // WAIT_STATES=3: back-to-back reads with the strobe held
        applyStimulus(1, 0, 1, 30'd7, 4'b1111, 32'h77770007);
        applyStimulus(1, 0, 1, 30'd8, 4'b1111, 32'h88880008);
        @(negedge clk);
        sel    = 1;
        addrIn = 30'd7;
        maskIn = 4'b1111;
        rdIn   = 1'b1;
        c0     = cyc;
        for (int k = 0; k < 3; k++) pushExpect(1, 1, 0, 30'd7, 4'b1111, 32'h0, c0 + 5 * k + 5);
        while (cyc < c0 + 11) @(negedge clk);
        rdIn = 1'b0;
        waitDrain();

        // Inputs changed while busy must not affect the request in flight
        @(negedge clk);
        sel    = 1;
        addrIn = 30'd7;
        rdIn   = 1'b1;
        pushExpect(1, 1, 0, 30'd7, 4'b1111, 32'h0, cyc + 5);
        @(negedge clk);
        rdIn   = 1'b0;
        wrIn   = 1'b1;
        addrIn = 30'd8;
        dataIn = 32'hBAD0BAD0;
        repeat (2) @(negedge clk);
        wrIn = 1'b0;
        waitDrain();
        applyStimulus(1, 1, 0, 30'd8, 4'b1111, 32'h0);

        // WAIT_STATES=2: reset during WAIT aborts the write
        applyStimulus(2, 0, 1, 30'd9, 4'b1111, 32'h11112222);
        applyStimulus(2, 1, 0, 30'd9, 4'b1111, 32'h0);
        @(negedge clk);
        sel    = 2;
        addrIn = 30'd9;
        maskIn = 4'b1111;
        dataIn = 32'h12345678;
        wrIn   = 1'b1;
        @(negedge clk);
        wrIn = 1'b0;
        checkOutput("busyInFlight", 64'(bsy[2]), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("abortData", 64'(dOut[2]), 64'd0);
        checkOutput("abortBusy", 64'(bsy[2]), 64'd0);
        checkOutput("abortDone", 64'(dn[2]), 64'd0);
        checkOutput("abortFault", 64'(flt[2]), 64'd0);
        for (int d = 0; d < 4; d++) lastOut[d] = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        applyStimulus(2, 1, 0, 30'd9, 4'b1111, 32'h0);
        applyStimulus(0, 1, 0, 30'd5, 4'b1111, 32'h0);

        waitDrain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
